// File: rtl/clock_display_pkg.sv
// Shared constants and types for the clock display path: active-low
// seven-segment patterns (bit 0 = a ... bit 6 = g), the all-anodes-off
// value, the scanner state encoding and the per-slot latched contents.
package clock_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // SCAN_RESTART is held through reset; the first edge after release
  // starts slot 0 from the top of its blanking interval.
  typedef enum logic {
    SCAN_RESTART = 1'b0,
    SCAN_RUN     = 1'b1
  } scan_state_e;

  // Contents captured at the start of each digit slot.
  typedef struct packed {
    logic [3:0] value;
    logic       point;
  } slot_reg_t;

  // Reset contents decode to a dark digit with the point off.
  localparam slot_reg_t SLOT_RESET = '{value: 4'hF, point: 1'b0};

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Values 10..15 decode to a dark digit.
module bcd_to_seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pattern lookup; anything outside 0..9 is blanked.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot lasts
// REFRESH_DIV cycles of MCLK (falling edge); the first BLANK_CYCLES of a
// slot keep every anode off while the segment lines settle on the new
// digit. Slot contents are captured when the slot starts.
// Optional build macro DISPLAY_BLINK_EN: blanks the segments of positions
// selected by blinkMask during alternate blink half-periods of
// BLINK_SLOTS full scans.
module display_scanner
  import clock_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_SLOTS  = 1024
)
(
  input  logic       MCLK,
  input  logic       resetSignal,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dpIn,
  input  logic [3:0] blinkMask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] anode
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_LIT  = PW'(BLANK_CYCLES);

  scan_state_e   state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [1:0]    slot_r, slot_s;
  slot_reg_t     slot_reg_r, slot_reg_s;
  logic [3:0]    digit_sel_s;
  logic          wrap_s;
  logic          load_s;
  logic          blank_s;
  logic [6:0]    dec_seg_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  logic [3:0]    anode_s;

  bcd_to_seg u_dec (
    .bcd (slot_reg_r.value),
    .seg (dec_seg_s)
  );

  // Scan state register.
  always_ff @(negedge MCLK or negedge resetSignal) begin
    if (!resetSignal) begin
      state_r <= SCAN_RESTART;
    end else begin
      state_r <= state_s;
    end
  end

  // Next scan state: the restart edge always leads into normal running.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SCAN_RESTART: state_s = SCAN_RUN;
      SCAN_RUN:     state_s = SCAN_RUN;
      default:      state_s = SCAN_RESTART;
    endcase
  end

  // Prescaler and slot index; a new slot begins on wrap or on restart.
  always_comb begin
    wrap_s  = 1'b0;
    load_s  = 1'b1;
    presc_s = {PW{1'b0}};
    slot_s  = 2'd0;
    if (state_r == SCAN_RUN) begin
      wrap_s = (presc_r == PRESC_LAST);
      load_s = wrap_s;
    end else begin
      wrap_s = 1'b0;
      load_s = 1'b1;
    end
    if (load_s) begin
      presc_s = {PW{1'b0}};
    end else begin
      presc_s = presc_r + PW'(1);
    end
    if (state_r != SCAN_RUN) begin
      slot_s = 2'd0;
    end else if (wrap_s) begin
      slot_s = slot_r + 2'd1;
    end else begin
      slot_s = slot_r;
    end
  end

  // Capture the digit and point of the slot that is about to start.
  always_comb begin
    digit_sel_s = 4'd0;
    case (slot_s)
      2'd0:    digit_sel_s = digit0;
      2'd1:    digit_sel_s = digit1;
      2'd2:    digit_sel_s = digit2;
      2'd3:    digit_sel_s = digit3;
      default: digit_sel_s = 4'd0;
    endcase
    slot_reg_s = slot_reg_r;
    if (load_s) begin
      slot_reg_s.value = digit_sel_s;
      slot_reg_s.point = dpIn[slot_s];
    end else begin
      slot_reg_s = slot_reg_r;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

  logic [BW-1:0] blink_cnt_r, blink_cnt_s;
  logic          blink_phase_r, blink_phase_s;
  logic          blink_sel_r, blink_sel_s;

  // Blink timing: count completed scans, flip the phase every BLINK_SLOTS.
  always_comb begin
    blink_cnt_s   = blink_cnt_r;
    blink_phase_s = blink_phase_r;
    if (wrap_s && (slot_r == 2'd3)) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_s   = {BW{1'b0}};
        blink_phase_s = ~blink_phase_r;
      end else begin
        blink_cnt_s   = blink_cnt_r + BW'(1);
        blink_phase_s = blink_phase_r;
      end
    end else begin
      blink_cnt_s   = blink_cnt_r;
      blink_phase_s = blink_phase_r;
    end
    if (load_s) begin
      blink_sel_s = blinkMask[slot_s];
    end else begin
      blink_sel_s = blink_sel_r;
    end
  end

  // Blink state registers.
  always_ff @(negedge MCLK or negedge resetSignal) begin
    if (!resetSignal) begin
      blink_cnt_r   <= {BW{1'b0}};
      blink_phase_r <= 1'b0;
      blink_sel_r   <= 1'b0;
    end else begin
      blink_cnt_r   <= blink_cnt_s;
      blink_phase_r <= blink_phase_s;
      blink_sel_r   <= blink_sel_s;
    end
  end

  assign blank_s = blink_sel_r & blink_phase_r;
`else
  // blinkMask has no effect in this build.
  logic unused_blink_mask_s;
  assign unused_blink_mask_s = ^blinkMask;
  assign blank_s = 1'b0;
`endif

  // Next output values: anode follows the next prescaler position so it
  // lines up with the slot; segments follow the already captured slot.
  always_comb begin
    anode_s = ANODES_OFF;
    if (presc_s < PRESC_LIT) begin
      anode_s = ANODES_OFF;
    end else begin
      anode_s = ~(4'b0001 << slot_s);
    end
    if (blank_s) begin
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
    end else begin
      seg_s = dec_seg_s;
      dp_s  = ~slot_reg_r.point;
    end
  end

  // Scan state and registered outputs.
  always_ff @(negedge MCLK or negedge resetSignal) begin
    if (!resetSignal) begin
      presc_r    <= {PW{1'b0}};
      slot_r     <= 2'd0;
      slot_reg_r <= SLOT_RESET;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      anode      <= ANODES_OFF;
    end else begin
      presc_r    <= presc_s;
      slot_r     <= slot_s;
      slot_reg_r <= slot_reg_s;
      seg        <= seg_s;
      dp         <= dp_s;
      anode      <= anode_s;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner. A cycle-indexed reference model
// derives the expected anode/seg/dp from the cycle count since restart.
// Honours DISPLAY_BLINK_EN in the same way as the design.
module tb_display_scanner;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 2;

  logic       MCLK = 1'b1;
  logic       resetSignal = 1'b0;
  logic [3:0] digit0 = 4'd0;
  logic [3:0] digit1 = 4'd0;
  logic [3:0] digit2 = 4'd0;
  logic [3:0] digit3 = 4'd0;
  logic [3:0] dpIn = 4'd0;
  logic [3:0] blinkMask = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] anode;

  int checks = 0;
  int failures = 0;
  int k = 0;
  bit blink_en;

  logic [3:0] lat_val;
  logic       lat_dp;
  logic       lat_blink;
  logic [6:0] prev_seg = 7'b1111111;
  logic       prev_dp = 1'b1;

  logic [6:0] seg_table [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                  7'b0110000, 7'b0011001, 7'b0010010,
                                  7'b0000010, 7'b1111000, 7'b0000000,
                                  7'b0010000};

  display_scanner #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK),
    .BLINK_SLOTS  (BLINK)
  ) dut (
    .MCLK        (MCLK),
    .resetSignal (resetSignal),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dpIn        (dpIn),
    .blinkMask   (blinkMask),
    .seg         (seg),
    .dp          (dp),
    .anode       (anode)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [3:0] digit_at(input int s);
    logic [3:0] r;
    case (s)
      0:       r = digit0;
      1:       r = digit1;
      2:       r = digit2;
      default: r = digit3;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // One MCLK cycle: sample at the rising edge (outputs move on falling).
  task automatic step();
    int presc, slot, scan;
    logic [3:0] exp_anode;
    bit blanked;
    @(posedge MCLK);
    presc = k % DIV;
    slot  = (k / DIV) % 4;
    scan  = k / (4 * DIV);
    if (presc == 0) begin
      lat_val   = digit_at(slot);
      lat_dp    = dpIn[slot];
      lat_blink = blinkMask[slot];
    end
    exp_anode = 4'b1111;
    if (presc >= BLANK) exp_anode[slot] = 1'b0;
    chk("anode", {3'b000, anode}, {3'b000, exp_anode});
    chk("seg", seg, prev_seg);
    chk("dp", {6'b000000, dp}, {6'b000000, prev_dp});
    checks++;
    assert ($countones(~anode) <= 1) else begin
      failures++;
      $error("FAIL onehot k=%0d observed anode=%b expected at most one low bit", k, anode);
    end
    // Segments shown next cycle reflect this cycle's captured slot.
    blanked  = blink_en && lat_blink && (((scan / BLINK) % 2) == 1);
    prev_seg = (blanked || lat_val > 4'd9) ? 7'b1111111 : seg_table[lat_val];
    prev_dp  = blanked ? 1'b1 : ~lat_dp;
    k++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_anode"}, {3'b000, anode}, 7'b0001111);
    chk({tag, "_seg"}, seg, 7'b1111111);
    chk({tag, "_dp"}, {6'b000000, dp}, 7'b0000001);
  endtask

  task automatic release_reset();
    resetSignal = 1'b1;
    k = 0;
    prev_seg = 7'b1111111;
    prev_dp = 1'b1;
  endtask

  initial begin
`ifdef DISPLAY_BLINK_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif
    // Power-on reset.
    repeat (2) @(posedge MCLK);
    check_reset_outputs("por");

    // Static digits 3/2/1/0 over two scans.
    digit0 = 4'd3; digit1 = 4'd2; digit2 = 4'd1; digit3 = 4'd0;
    release_reset();
    repeat (64) step();

    // digit1 changes 5 -> 7 in the middle of slot 1.
    digit1 = 4'd5;
    for (int i = 0; i < 32 && (k % 32) != 12; i++) step();
    digit1 = 4'd7;
    repeat (64) step();

    // Out-of-range digit and a single decimal point.
    digit2 = 4'd12; dpIn = 4'b0100;
    repeat (64) step();

    // Blinking of position 0.
    digit2 = 4'd4; dpIn = 4'b0000; blinkMask = 4'b0001;
    repeat (256) step();

    // Reset pulse in the middle of slot 2.
    for (int i = 0; i < 32 && (k % 32) != 20; i++) step();
    #2 resetSignal = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge MCLK);
    check_reset_outputs("midrst_hold");
    release_reset();
    repeat (64) step();

    // Long random run.
    for (int i = 0; i < 10000; i++) begin
      step();
      digit0 = 4'($urandom_range(0, 15));
      digit1 = 4'($urandom_range(0, 15));
      digit2 = 4'($urandom_range(0, 15));
      digit3 = 4'($urandom_range(0, 15));
      dpIn = 4'($urandom_range(0, 15));
      blinkMask = 4'($urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 12500: MCLK cycles per digit slot; legal range BLANK_CYCLES+2 .. 2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: all-anodes-off cycles at the start of each slot; legal range 1 .. REFRESH_DIV-2.
REQ-003 SHALL have parameter BLINK_SLOTS, default 1024: full 4-slot scans per blink half-period.
REQ-004 SHALL have port MCLK input 1: system clock; all state updates on its falling edge.
REQ-005 SHALL have port resetSignal input 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports digit0..digit3 input 4 each: BCD values from the digit counters; digit0 is rightmost.
REQ-007 SHALL have port dpIn input 4: decimal-point request per position, active-high.
REQ-008 SHALL have port blinkMask input 4: positions to blink while being edited, active-high.
REQ-009 SHALL have port seg output 7: segments a..g on bits 0..6, active-low, registered.
REQ-010 SHALL have port dp output 1: decimal point, active-low, registered.
REQ-011 SHALL have port anode output 4: position enables, bit n for digit n, active-low, registered.

Function
REQ-012 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0.
REQ-013 SHALL advance a 2-bit slot index 0->1->2->3->0 on each prescaler wrap.
REQ-014 SHALL, on the edge where the slot index changes, latch digit<slot>, dpIn[slot] and blinkMask[slot] into a slot register; input changes mid-slot SHALL NOT affect outputs until the next slot.
REQ-015 SHALL drive anode=1111 while prescaler < BLANK_CYCLES, and anode = ~(1<<slot) from prescaler = BLANK_CYCLES through REFRESH_DIV-1.
REQ-016 SHALL drive seg and dp from the slot register starting on the edge after latching, so both are stable before the anode turns on.
REQ-017 SHALL decode values 0..9 to standard 7-segment patterns (e.g. 0 -> 1000000, 1 -> 1111001, 8 -> 0000000).
REQ-018 SHALL drive seg=1111111 for values 10..15.
REQ-019 SHALL NOT assert more than one anode in any cycle.
REQ-020 SHALL, on scan completion (wrap of slot 3 to slot 0), increment a blink counter; at BLINK_SLOTS-1 it SHALL wrap to 0 and toggle blinkPhase.

Reset
REQ-021 SHALL, while resetSignal=0, force anode=1111, seg=1111111, dp=1, prescaler=0, slot=0, blink counter=0 and blinkPhase=0, independent of MCLK.
REQ-022 SHALL restart on the first falling MCLK edge after resetSignal rises, with slot 0 and the blanking interval.
REQ-023 SHALL, when reset is asserted mid-slot, blank all outputs immediately with no partial-slot continuation.

Configuration
REQ-024 SHALL, when DISPLAY_BLINK_EN is defined, blank seg and dp for a latched position whose blinkMask bit is 1 while blinkPhase=1; the anode SHALL keep its normal timing.
REQ-025 SHALL, when DISPLAY_BLINK_EN is not defined, ignore blinkMask, omit the blink counter and blinkPhase, and keep all other behaviour identical.

Structure
REQ-026 SHALL place the segment pattern constants for 0..9 and blank, plus the ANODES_OFF constant, in the shared package clock_display_pkg.
REQ-027 SHALL implement decoding in a purely combinational sub-module bcd_to_seg (4-bit in, 7-bit active-low out), instantiated once.

Verification
REQ-028 SHALL cover: REFRESH_DIV=8, BLANK_CYCLES=2, digits 3/2/1/0 -> per slot, anode=1111 for 2 cycles, then 1110 with seg=0110000 (3) for 6 cycles, then 1101 with 0100100 (2), and so on.
REQ-029 SHALL cover: digit1 changes 5->7 mid-slot 1 -> seg stays 0010010 until slot 1 next recurs, then shows 1111000.
REQ-030 SHALL cover: digit2=12 and dpIn=0100 -> slot 2 shows seg=1111111, dp=0; all other slots show dp=1.
REQ-031 SHALL cover: with DISPLAY_BLINK_EN defined, BLINK_SLOTS=2, blinkMask=0001 -> slot 0 seg is blanked on alternate pairs of scans while anode timing is unchanged; without the macro, it is never blanked.
REQ-032 SHALL cover: resetSignal pulsed low mid-slot 2 -> same-instant anode=1111, seg=1111111; after release, the first lit position is anode=1110 after exactly 2 blank cycles.
REQ-033 SHALL cover: a continuous run of at least 10000 cycles with random digits -> an assertion that at most one anode bit is 0 in every cycle.
